// File: rtl/aes_round_key_xor_pkg.sv
// Shared definitions for the AES AddRoundKey engine and related key blocks.
//
// Contents:
//   state_e    - FSM state encoding for the sweep engine (IDLE/RD/WR/FIN)
//   DEF_*      - default datapath geometry (word width, state size, rounds)
//   key_base() - maps a round index to the first expanded-key word of that
//                round. Encrypt walks keys forward and decrypt walks them
//                backward. Key-expansion blocks can reuse this mapping.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_STATE_WORDS = 16;
  localparam int DEF_NR          = 14;

  // Decrypt applies the round keys in reverse order, so round r uses key
  // block (nr - r). The caller must guarantee round_idx <= nr. Otherwise the
  // subtraction wraps and the result is meaningless.
  function automatic int unsigned key_base(input int unsigned round_idx,
                                           input logic        decrypt,
                                           input int unsigned nr,
                                           input int unsigned state_words);
    int unsigned blk;
    blk = decrypt ? (nr - round_idx) : round_idx;
    return blk * state_words;
  endfunction

endpackage

// File: rtl/aes_round_key_xor_if.sv
// Bundle of the block-level handshake and memory ports of the AddRoundKey
// engine.
//
// Signals:
//   ap_start/ap_done/ap_idle/ap_ready - ap_ctrl_hs block handshake
//   round_idx, decrypt                - operation selectors, latched at start
//   key_err                           - status of the last operation
//   statemt_*                         - single-port state RAM (read latency 1)
//   key_*                             - expanded-key ROM (read latency 1)
//
// Modports:
//   master - the host side: drives start/selectors and returns memory data
//   slave  - the engine side: drives handshake status and memory requests
interface aes_round_key_xor_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int KADDR_W = 8,
  parameter int RIDX_W  = 4
);

  logic               ap_start;
  logic               ap_done;
  logic               ap_idle;
  logic               ap_ready;
  logic [RIDX_W-1:0]  round_idx;
  logic               decrypt;
  logic               key_err;

  logic [ADDR_W-1:0]  statemt_address0;
  logic               statemt_ce0;
  logic               statemt_we0;
  logic [DATA_W-1:0]  statemt_d0;
  logic [DATA_W-1:0]  statemt_q0;

  logic [KADDR_W-1:0] key_address0;
  logic               key_ce0;
  logic [DATA_W-1:0]  key_q0;

  modport master (
    output ap_start, round_idx, decrypt, statemt_q0, key_q0,
    input  ap_done, ap_idle, ap_ready, key_err,
    input  statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
    input  key_address0, key_ce0
  );

  modport slave (
    input  ap_start, round_idx, decrypt, statemt_q0, key_q0,
    output ap_done, ap_idle, ap_ready, key_err,
    output statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
    output key_address0, key_ce0
  );

endinterface

// File: rtl/aes_round_key_xor.sv
// AddRoundKey engine: on each accepted ap_start it sweeps the state RAM,
// XORs every word with the matching word of the selected round key, and
// writes the result back in place.
//
// Ports:
//   ap_clk   - clock
//   ap_rst_n - asynchronous active-low reset
//   bus      - aes_round_key_xor_if.slave. It carries the handshake
//              (ap_start/done/idle/ready), the selectors (round_idx,
//              decrypt), the key_err status, and the state RAM and key ROM
//              ports.
//
// Each word takes two cycles. RD issues the RAM and ROM reads. WR writes the
// XOR of the two read results back to the same address. Splitting the work
// this way keeps the single-port state RAM free of simultaneous read and
// write.
module aes_round_key_xor
  import aes_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STATE_WORDS = DEF_STATE_WORDS,
  parameter int NR          = DEF_NR,
  parameter int ADDR_W      = $clog2(STATE_WORDS),
  parameter int KADDR_W     = $clog2((NR + 1) * STATE_WORDS)
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  aes_round_key_xor_if.slave bus
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  i_q, i_d;
  logic [KADDR_W-1:0] kbase_q, kbase_d;
  logic               key_err_q, key_err_d;

  logic               range_err;
  logic [KADDR_W-1:0] kbase_calc;
  logic               last_word;

  // A round index above NR has no key block. Such an op is rejected before
  // any memory access.
  assign range_err  = int'(bus.round_idx) > NR;
  assign kbase_calc = KADDR_W'(key_base(32'(bus.round_idx), bus.decrypt,
                                        NR, STATE_WORDS));
  assign last_word  = (i_q == ADDR_W'(STATE_WORDS - 1));

  // State, word counter, latched key base and error status.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      kbase_q   <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      kbase_q   <= kbase_d;
      key_err_q <= key_err_d;
    end
  end

  // Next-state and output decode. Outputs default to their idle values, so
  // an asynchronous reset takes every output straight back to the reset
  // state.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    kbase_d   = kbase_q;
    key_err_d = key_err_q;

    bus.ap_done          = 1'b0;
    bus.ap_ready         = 1'b0;
    bus.ap_idle          = 1'b0;
    bus.statemt_address0 = '0;
    bus.statemt_ce0      = 1'b0;
    bus.statemt_we0      = 1'b0;
    bus.statemt_d0       = '0;
    bus.key_address0     = '0;
    bus.key_ce0          = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) begin
          i_d = '0;
          if (range_err) begin
            key_err_d = 1'b1;
            state_d   = FIN;
          end else begin
            key_err_d = 1'b0;
            kbase_d   = kbase_calc;
            state_d   = RD;
          end
        end
      end

      RD: begin
        bus.statemt_address0 = i_q;
        bus.statemt_ce0      = 1'b1;
        bus.key_address0     = kbase_q + KADDR_W'(i_q);
        bus.key_ce0          = 1'b1;
        state_d              = WR;
      end

      // Both memories return data one cycle after RD, so the read results
      // are valid here and can be combined directly into the write data.
      WR: begin
        bus.statemt_address0 = i_q;
        bus.statemt_ce0      = 1'b1;
        bus.statemt_we0      = 1'b1;
        bus.statemt_d0       = bus.statemt_q0 ^ bus.key_q0;
        if (last_word) begin
          state_d = FIN;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = RD;
        end
      end

      FIN: begin
        bus.ap_done  = 1'b1;
        bus.ap_ready = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.key_err = key_err_q;

endmodule

// File: tb/tb_aes_round_key_xor.sv
// Directed testbench for aes_round_key_xor. It provides a behavioural state
// RAM and key ROM (both read latency 1) and runs a linear sequence of
// operations. Expected values are written out by hand.
module tb_aes_round_key_xor;

  localparam int DATA_W      = 32;
  localparam int STATE_WORDS = 16;
  localparam int NR          = 14;
  localparam int ADDR_W      = 4;
  localparam int KADDR_W     = 8;
  localparam int RIDX_W      = 4;
  localparam int KEY_WORDS   = (NR + 1) * STATE_WORDS;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  always #5 ap_clk = ~ap_clk;

  aes_round_key_xor_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KADDR_W(KADDR_W), .RIDX_W(RIDX_W)
  ) bus ();

  aes_round_key_xor #(
    .DATA_W(DATA_W), .STATE_WORDS(STATE_WORDS), .NR(NR),
    .ADDR_W(ADDR_W), .KADDR_W(KADDR_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  // Memory models. loadState reinitialises the RAM to state[i] = i.
  logic [DATA_W-1:0] stateRam [STATE_WORDS];
  logic [DATA_W-1:0] keyRom   [KEY_WORDS];
  logic              loadState = 1'b0;

  always @(posedge ap_clk) begin
    if (loadState) begin
      for (int k = 0; k < STATE_WORDS; k++) stateRam[k] <= 32'(k);
    end else if (bus.statemt_ce0 && bus.statemt_we0) begin
      stateRam[bus.statemt_address0] <= bus.statemt_d0;
    end
    if (bus.statemt_ce0 && !bus.statemt_we0)
      bus.statemt_q0 <= stateRam[bus.statemt_address0];
    if (bus.key_ce0)
      bus.key_q0 <= keyRom[bus.key_address0];
  end

  // Bus monitor. It counts done pulses, RAM enables and protocol violations,
  // and logs every key address issued.
  int                 doneCount = 0;
  int                 protoViol = 0;
  int                 ceCount   = 0;
  logic [KADDR_W-1:0] keyLog [$];

  always @(posedge ap_clk) begin
    if (bus.ap_done) doneCount++;
    if (bus.statemt_we0 && !bus.statemt_ce0) protoViol++;
    if (bus.ap_done !== bus.ap_ready) protoViol++;
    if (bus.statemt_ce0) ceCount++;
    if (bus.key_ce0) keyLog.push_back(bus.key_address0);
  end

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [RIDX_W-1:0] ridx, input logic dec);
    @(negedge ap_clk);
    bus.round_idx = ridx;
    bus.decrypt   = dec;
    bus.ap_start  = 1'b1;
  endtask

  task automatic reloadState();
    @(negedge ap_clk);
    loadState = 1'b1;
    @(negedge ap_clk);
    loadState = 1'b0;
  endtask

  // Counts rising edges from the start-sampling edge until ap_done is seen.
  // The count is bounded so a stuck DUT still reaches the summary.
  task automatic waitDone(input bit holdStart, output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(posedge ap_clk);
      cycles++;
      @(negedge ap_clk);
      if (!holdStart) bus.ap_start = 1'b0;
      if (bus.ap_done) break;
    end
  endtask

  initial begin
    int cyc;
    int base;
    int ceBefore;
    int doneBefore;
    bit found;

    bus.ap_start  = 1'b0;
    bus.round_idx = '0;
    bus.decrypt   = 1'b0;
    for (int k = 0; k < KEY_WORDS; k++)
      keyRom[k] = (k < STATE_WORDS) ? 32'hA5A5_A5A5 : (32'h5A00_0000 | 32'(k));

    // Reset values.
    #1;
    checkOutput("rst_idle",   bus.ap_idle, 1);
    checkOutput("rst_done",   {bus.ap_done, bus.ap_ready}, 0);
    checkOutput("rst_keyerr", bus.key_err, 0);
    checkOutput("rst_en",     {bus.statemt_ce0, bus.statemt_we0, bus.key_ce0}, 0);
    checkOutput("rst_addr",   {bus.statemt_address0, bus.key_address0}, 0);
    checkOutput("rst_d0",     bus.statemt_d0, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Encrypt, round 0.
    reloadState();
    base = keyLog.size();
    applyStimulus(4'd0, 1'b0);
    waitDone(1'b0, cyc);
    checkOutput("enc0_latency", cyc, 33);
    checkOutput("enc0_keyerr",  bus.key_err, 0);
    checkOutput("enc0_nkeys",   keyLog.size() - base, 16);
    for (int i = 0; i < STATE_WORDS; i++) begin
      checkOutput($sformatf("enc0_kaddr%0d", i), keyLog[base + i], 64'(i));
      checkOutput($sformatf("enc0_word%0d", i), stateRam[i], 64'(32'(i) ^ 32'hA5A5_A5A5));
    end

    // Decrypt, round 3. Keys are read from word (14-3)*16 = 176.
    reloadState();
    base = keyLog.size();
    applyStimulus(4'd3, 1'b1);
    waitDone(1'b0, cyc);
    checkOutput("dec3_latency", cyc, 33);
    checkOutput("dec3_nkeys",   keyLog.size() - base, 16);
    checkOutput("dec3_word0",   stateRam[0], 64'h5A00_00B0);
    checkOutput("dec3_word15",  stateRam[15], 64'h5A00_00B0);
    for (int i = 0; i < STATE_WORDS; i++) begin
      checkOutput($sformatf("dec3_kaddr%0d", i), keyLog[base + i], 64'(176 + i));
      checkOutput($sformatf("dec3_word%0d", i), stateRam[i],
                  64'(32'(i) ^ (32'h5A00_0000 | 32'(176 + i))));
    end

    // Out-of-range round index. No memory access; key_err holds afterwards.
    ceBefore = ceCount;
    applyStimulus(4'd15, 1'b0);
    waitDone(1'b0, cyc);
    checkOutput("err_latency", cyc, 1);
    checkOutput("err_keyerr",  bus.key_err, 1);
    repeat (3) @(negedge ap_clk);
    checkOutput("err_no_ce",   ceCount - ceBefore, 0);
    checkOutput("err_hold",    bus.key_err, 1);
    checkOutput("err_idle",    bus.ap_idle, 1);
    checkOutput("err_ram0",    stateRam[0], 64'h5A00_00B0);
    checkOutput("err_ram9",    stateRam[9], 64'(32'd9 ^ 32'h5A00_00B9));

    // Back-to-back with ap_start held high. The same round is applied twice,
    // which restores the state.
    reloadState();
    doneBefore = doneCount;
    applyStimulus(4'd0, 1'b0);
    waitDone(1'b1, cyc);
    checkOutput("b2b_latency1", cyc, 33);
    checkOutput("b2b_keyerr",   bus.key_err, 0);
    @(negedge ap_clk);
    checkOutput("b2b_gap_idle", bus.ap_idle, 1);
    @(negedge ap_clk);
    checkOutput("b2b_rd", {bus.statemt_ce0, bus.statemt_we0, bus.ap_idle}, 3'b100);
    bus.ap_start = 1'b0;
    waitDone(1'b0, cyc);
    checkOutput("b2b_latency2", cyc, 32);
    @(negedge ap_clk);
    checkOutput("b2b_done_pulses", doneCount - doneBefore, 2);
    for (int i = 0; i < STATE_WORDS; i++)
      checkOutput($sformatf("b2b_word%0d", i), stateRam[i], 64'(i));

    // Reset during the WR cycle of word 7.
    reloadState();
    applyStimulus(4'd0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      if (bus.statemt_we0 && bus.statemt_address0 == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("mid_found_wr7", found, 1);
    #1 ap_rst_n = 1'b0;
    #1;
    checkOutput("mid_idle",  bus.ap_idle, 1);
    checkOutput("mid_en",    {bus.statemt_ce0, bus.statemt_we0, bus.key_ce0}, 0);
    checkOutput("mid_addr",  {bus.statemt_address0, bus.key_address0}, 0);
    checkOutput("mid_d0",    bus.statemt_d0, 0);
    checkOutput("mid_done",  {bus.ap_done, bus.ap_ready}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checkOutput("mid_idle_after", bus.ap_idle, 1);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("mid_mod%0d", i), stateRam[i], 64'(32'(i) ^ 32'hA5A5_A5A5));
    for (int i = 8; i < STATE_WORDS; i++)
      checkOutput($sformatf("mid_keep%0d", i), stateRam[i], 64'(i));

    // A start pulse while busy is ignored. Selector changes after the start
    // do not affect the running op.
    reloadState();
    doneBefore = doneCount;
    applyStimulus(4'd0, 1'b0);
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      cyc = c;
      if (c == 1) begin
        bus.ap_start  = 1'b0;
        bus.round_idx = 4'd3;
        bus.decrypt   = 1'b1;
      end
      if (c == 10) bus.ap_start = 1'b1;
      if (c == 11) bus.ap_start = 1'b0;
      if (bus.ap_done) break;
    end
    checkOutput("busy_latency", cyc, 33);
    repeat (5) @(negedge ap_clk);
    checkOutput("busy_one_done", doneCount - doneBefore, 1);
    checkOutput("busy_idle",     bus.ap_idle, 1);
    for (int i = 0; i < STATE_WORDS; i++)
      checkOutput($sformatf("busy_word%0d", i), stateRam[i], 64'(32'(i) ^ 32'hA5A5_A5A5));
    checkOutput("proto_we_without_ce", protoViol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
